seq_pattern_tx: RTL and testbench

- Serial pattern transmitter. It is the source side of the serial bit stream that feeds the sequence detectors, e.g. the 1011 detector.
- Accepts a parallel WIDTH-bit pattern over a valid/ready handshake.
- Shifts the pattern out MSB-first, one bit per clock, repeating it a programmable number of times with an optional idle gap between frames.
- Used as a synthesizable stimulus source and as the transmit end of on-chip serial pattern links.

---
 rtl/seq_pattern_tx.sv | 113 +++++++++++
 tb/tb_seq_pattern_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched WIDTH-bit pattern out MSB-first, rep_cnt+1 frames,
// with GAP_CYCLES idle cycles between frames. All outputs are registered.
module seq_pattern_tx #(
  parameter int   WIDTH      = 4,
  parameter int   GAP_CYCLES = 0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pat_in,
  input  logic [3:0]       rep_cnt,
  input  logic             pat_valid,
  output logic             pat_ready,
  output logic             data_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LEN  = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state;
  logic [WIDTH-1:0] pat;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bidx;
  logic [3:0]       frames;
  logic [3:0]       gap_cnt;

  // bidx is the index of the bit currently on data_out; shreg holds the bits still to come.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      pat         <= '0;
      shreg       <= '0;
      bidx        <= '0;
      frames      <= '0;
      gap_cnt     <= '0;
      data_out    <= IDLE_LEVEL;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pat_ready   <= 1'b0;
    end else begin
      done        <= 1'b0;
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          pat_ready <= 1'b1;
          if (pat_valid && pat_ready) begin
            pat         <= pat_in;
            frames      <= rep_cnt;
            shreg       <= {pat_in[WIDTH-2:0], 1'b0};
            data_out    <= pat_in[WIDTH-1];
            bidx        <= '0;
            bit_valid   <= 1'b1;
            frame_start <= 1'b1;
            busy        <= 1'b1;
            pat_ready   <= 1'b0;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          if (bidx != LAST_BIT) begin
            data_out <= shreg[WIDTH-1];
            shreg    <= {shreg[WIDTH-2:0], 1'b0};
            bidx     <= bidx + BW'(1);
          end else if (frames != 4'd0) begin
            frames <= frames - 4'd1;
            if (GAP_CYCLES > 0) begin
              state     <= GAP;
              gap_cnt   <= 4'd1;
              data_out  <= IDLE_LEVEL;
              bit_valid <= 1'b0;
            end else begin
              // Back-to-back frames: reload without a bubble.
              data_out    <= pat[WIDTH-1];
              shreg       <= {pat[WIDTH-2:0], 1'b0};
              bidx        <= '0;
              frame_start <= 1'b1;
            end
          end else begin
            state     <= IDLE;
            data_out  <= IDLE_LEVEL;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            pat_ready <= 1'b1;
            done      <= 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LEN) begin
            state       <= SHIFT;
            data_out    <= pat[WIDTH-1];
            shreg       <= {pat[WIDTH-2:0], 1'b0};
            bidx        <= '0;
            bit_valid   <= 1'b1;
            frame_start <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: two instances (no gap / 2-cycle gap) checked every cycle against a
// queue-based model of the expected output stream, plus directed literal checks.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] pat_in = 4'd0;
  logic [3:0] rep_cnt = 4'd0;
  logic       pat_valid = 1'b0;
  logic       pat_ready0, data_out0, bit_valid0, frame_start0, busy0, done0;
  logic       pat_ready1, data_out1, bit_valid1, frame_start1, busy1, done1;

  always #5 clk = ~clk;

  seq_pattern_tx #(.WIDTH(4), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .pat_in(pat_in), .rep_cnt(rep_cnt), .pat_valid(pat_valid),
    .pat_ready(pat_ready0), .data_out(data_out0), .bit_valid(bit_valid0),
    .frame_start(frame_start0), .busy(busy0), .done(done0));

  seq_pattern_tx #(.WIDTH(4), .GAP_CYCLES(2), .IDLE_LEVEL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .pat_in(pat_in), .rep_cnt(rep_cnt), .pat_valid(pat_valid),
    .pat_ready(pat_ready1), .data_out(data_out1), .bit_valid(bit_valid1),
    .frame_start(frame_start1), .busy(busy1), .done(done1));

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h required %0h", name, got, want);
  endtask

  // One record per output cycle: {data_out, bit_valid, frame_start, busy, pat_ready, done}
  typedef logic [5:0] rec_t;
  rec_t bq[$];
  rec_t q0[$];
  rec_t q1[$];
  rec_t exp0, exp1;
  bit   started = 1'b0;

  task automatic build(input logic [3:0] p, input logic [3:0] r, input int gap, input logic il);
    bq.delete();
    for (int f = 0; f <= int'(r); f++) begin
      if (f > 0)
        for (int g = 0; g < gap; g++) bq.push_back({il, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      for (int i = 0; i < 4; i++) bq.push_back({p[3-i], 1'b1, (i == 0), 1'b1, 1'b0, 1'b0});
    end
    bq.push_back({il, 5'b00011});
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      q0.delete();
      q1.delete();
      exp0 = 6'b000000;
      exp1 = 6'b100000;
    end else begin
      if (pat_valid && exp0[1]) begin build(pat_in, rep_cnt, 0, 1'b0); q0 = bq; end
      if (pat_valid && exp1[1]) begin build(pat_in, rep_cnt, 2, 1'b1); q1 = bq; end
      if (q0.size() > 0) exp0 = q0.pop_front(); else exp0 = 6'b000010;
      if (q1.size() > 0) exp1 = q1.pop_front(); else exp1 = 6'b100010;
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk($sformatf("stream0@%0t", $time),
          {data_out0, bit_valid0, frame_start0, busy0, pat_ready0, done0}, exp0);
      chk($sformatf("stream1@%0t", $time),
          {data_out1, bit_valid1, frame_start1, busy1, pat_ready1, done1}, exp1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(pat_ready0 && pat_ready1) && n < 200) begin tick(); n++; end
    chk("wait_idle", {31'd0, pat_ready0 && pat_ready1}, 32'd1);
  endtask

  task automatic send(input logic [3:0] p, input logic [3:0] r);
    wait_idle();
    pat_in = p; rep_cnt = r; pat_valid = 1'b1;
    tick();
    pat_valid = 1'b0;
  endtask

  initial begin
    logic [3:0]  lit;
    logic [7:0]  v8, f8;
    logic [9:0]  v10, bv10;

    // Pin the model against hand-computed streams.
    build(4'b1011, 4'd1, 0, 1'b0);
    chk("model_len_rep1", bq.size(), 9);
    v8 = '0; f8 = '0;
    for (int i = 0; i < 8; i++) begin v8 = {v8[6:0], bq[i][5]}; f8 = {f8[6:0], bq[i][3]}; end
    chk("model_data_rep1", v8, 8'b10111011);
    chk("model_fs_rep1", f8, 8'b10001000);
    chk("model_done_rep1", bq[8], 6'b000011);
    build(4'b1100, 4'd1, 2, 1'b1);
    chk("model_len_gap", bq.size(), 11);
    v10 = '0; bv10 = '0;
    for (int i = 0; i < 10; i++) begin v10 = {v10[8:0], bq[i][5]}; bv10 = {bv10[8:0], bq[i][4]}; end
    chk("model_data_gap", v10, 10'b1100111100);
    chk("model_valid_gap", bv10, 10'b1111001111);
    build(4'b0101, 4'd15, 0, 1'b0);
    chk("model_len_rep15", bq.size(), 65);

    repeat (3) tick();
    chk("reset_busy", busy0, 0);
    chk("reset_data1", data_out1, 1);
    reset = 1'b1;
    tick();
    chk("ready_after_reset", pat_ready0, 1);

    // Single frame 1011.
    lit = 4'b1011;
    send(4'b1011, 4'd0);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("single_bit%0d", k), data_out0, lit[4-k]);
      chk($sformatf("single_fs%0d", k), frame_start0, (k == 1));
      tick();
    end
    chk("single_done", done0, 1);
    chk("single_ready", pat_ready0, 1);

    // Two contiguous frames.
    send(4'b1011, 4'd1);
    v8 = '0;
    for (int k = 1; k <= 8; k++) begin v8 = {v8[6:0], data_out0}; tick(); end
    chk("contig_data", v8, 8'b10111011);
    chk("contig_done", done0, 1);

    // Two frames with a 2-cycle gap on the second instance.
    send(4'b1100, 4'd1);
    v10 = '0; bv10 = '0;
    for (int k = 1; k <= 10; k++) begin
      v10 = {v10[8:0], data_out1}; bv10 = {bv10[8:0], bit_valid1}; tick();
    end
    chk("gap_data", v10, 10'b1100111100);
    chk("gap_valid", bv10, 10'b1111001111);
    chk("gap_done", done1, 1);

    // pat_valid held through SHIFT with a new pattern: accepted in the done cycle.
    wait_idle();
    pat_in = 4'b1011; rep_cnt = 4'd0; pat_valid = 1'b1;
    tick();
    pat_in = 4'b0110;
    repeat (4) tick();
    chk("held_done", done0, 1);
    chk("held_ready", pat_ready0, 1);
    tick();
    pat_valid = 1'b0;
    chk("held_first_bit", data_out0, 0);
    chk("held_fs", frame_start0, 1);
    chk("held_valid", bit_valid0, 1);

    // Reset at the second bit of a frame.
    send(4'b1011, 4'd0);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("abort_data0", data_out0, 0);
    chk("abort_data1", data_out1, 1);
    chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0);
    tick();
    chk("abort_ready", pat_ready0, 1);
    chk("abort_no_done", done0, 0);

    // Reset held low with pat_valid high.
    reset = 1'b0; pat_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rst_hold_valid0", bit_valid0, 0);
      chk("rst_hold_valid1", bit_valid1, 0);
    end
    pat_valid = 1'b0; reset = 1'b1;
    tick();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      reset     = ($urandom_range(0, 199) != 0);
      pat_valid = ($urandom_range(0, 3) == 0);
      pat_in    = 4'($urandom);
      rep_cnt   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      tick();
    end
    pat_valid = 1'b0; reset = 1'b1;
    wait_idle();
    repeat (3) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
